// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
//   Time-multiplexed scan controller for NDIG common-anode 7-segment digits
//   sharing one registered BCD-to-7-segment decoder. Each digit slot is BLANK
//   cycles dark (decoder settles on the next digit's value) followed by DWELL
//   cycles lit. New frames are accepted through a one-entry pending buffer
//   and become active only at the frame boundary.
//
// Ports
//   clock       system clock, all state updates on posedge
//   reset_n     asynchronous active-low reset
//   wr_valid    new frame offered on wr_data
//   wr_ready    pending buffer empty, a frame can be accepted
//   wr_data     NDIG BCD digits, digit k at [4k+3:4k]
//   lz_en       leading-zero suppression enable
//   dec_val     BCD value for the shared decoder (digit currently scanned)
//   digit_en    active-low one-hot digit enable
//   frame_done  one-cycle pulse on the last cycle of each frame
module seg7_scan_ctrl #(
  parameter int NDIG  = 4,
  parameter int DWELL = 1000,
  parameter int BLANK = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [4*NDIG-1:0] wr_data,
  input  logic              lz_en,
  output logic [3:0]        dec_val,
  output logic [NDIG-1:0]   digit_en,
  output logic              frame_done
);

  localparam int CMAX = (BLANK > DWELL) ? BLANK : DWELL;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int IW   = $clog2(NDIG);
  localparam int FW   = 4 * NDIG;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NDIG - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t          state_r, state_s;
  logic [IW-1:0]   idx_r, idx_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic [FW-1:0]   active_r, active_s;
  logic [FW-1:0]   pending_r, pending_s;
  logic            pend_full_r, pend_full_s;
  logic            boundary_s;
  logic [NDIG-1:0] digit_en_s;
  logic            frame_done_s;

  // Select BCD digit k of a frame.
  function automatic logic [3:0] nibble(input logic [FW-1:0] frame,
                                        input logic [IW-1:0] k);
    return frame[{k, 2'b00} +: 4];
  endfunction

  // Digit k is dark when suppression is on, k is not the units digit and
  // digit k and everything above it are zero.
  function automatic logic lz_blank(input logic [FW-1:0] frame,
                                    input logic [IW-1:0] k,
                                    input logic          lz);
    logic nonzero;
    nonzero = 1'b0;
    for (int j = 0; j < NDIG; j++) begin
      if ((j >= int'(k)) && (frame[4*j +: 4] != 4'd0)) begin
        nonzero = 1'b1;
      end else begin
        nonzero = nonzero;
      end
    end
    return lz && (k != IW'(0)) && !nonzero;
  endfunction

  // Next scan position, frame buffers and next-cycle output values.
  always_comb begin
    state_s     = state_r;
    idx_s       = idx_r;
    cnt_s       = cnt_r;
    active_s    = active_r;
    pending_s   = pending_r;
    pend_full_s = pend_full_r;
    boundary_s  = 1'b0;

    case (state_r)
      ST_BLANK: begin
        if (cnt_r == BLANK_LAST) begin
          state_s = ST_SHOW;
          cnt_s   = {CW{1'b0}};
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      ST_SHOW: begin
        if (cnt_r == DWELL_LAST) begin
          state_s = ST_BLANK;
          cnt_s   = {CW{1'b0}};
          if (idx_r == IDX_LAST) begin
            idx_s      = {IW{1'b0}};
            boundary_s = 1'b1;
          end else begin
            idx_s = idx_r + IW'(1);
          end
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      default: begin
        state_s = ST_BLANK;
        idx_s   = {IW{1'b0}};
        cnt_s   = {CW{1'b0}};
      end
    endcase

    // Pending frame is promoted only at the boundary; a write landing on the
    // boundary with an empty buffer therefore waits a full frame.
    if (boundary_s && pend_full_r) begin
      active_s    = pending_r;
      pend_full_s = 1'b0;
    end else begin
      active_s = active_r;
    end

    if (wr_valid && !pend_full_r) begin
      pending_s   = wr_data;
      pend_full_s = 1'b1;
    end else begin
      pending_s = pending_r;
    end

    // Outputs are registered from next-state values so they line up with
    // the state they describe.
    digit_en_s = {NDIG{1'b1}};
    if ((state_s == ST_SHOW) && !lz_blank(active_s, idx_s, lz_en)) begin
      digit_en_s[idx_s] = 1'b0;
    end else begin
      digit_en_s = {NDIG{1'b1}};
    end

    frame_done_s = (state_s == ST_SHOW) && (cnt_s == DWELL_LAST) &&
                   (idx_s == IDX_LAST);
  end

  // Scan FSM, frame buffers and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_BLANK;
      idx_r       <= {IW{1'b0}};
      cnt_r       <= {CW{1'b0}};
      active_r    <= {FW{1'b0}};
      pending_r   <= {FW{1'b0}};
      pend_full_r <= 1'b0;
      wr_ready    <= 1'b1;
      dec_val     <= 4'd0;
      digit_en    <= {NDIG{1'b1}};
      frame_done  <= 1'b0;
    end else begin
      state_r     <= state_s;
      idx_r       <= idx_s;
      cnt_r       <= cnt_s;
      active_r    <= active_s;
      pending_r   <= pending_s;
      pend_full_r <= pend_full_s;
      wr_ready    <= !pend_full_s;
      dec_val     <= nibble(active_s, idx_s);
      digit_en    <= digit_en_s;
      frame_done  <= frame_done_s;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl
//   Scoreboard bench for seg7_scan_ctrl (NDIG=4, DWELL=4, BLANK=2).
//   A reference model tracks the active/pending frames and derives every
//   output from the cycle count since reset release (frame position, slot,
//   blank/show phase). Expected outputs are queued each clock; a monitor
//   pops and compares them on the falling edge.
module tb_seg7_scan_ctrl;

  localparam int NDIG  = 4;
  localparam int DWELL = 4;
  localparam int BLANK = 2;
  localparam int SLOT  = BLANK + DWELL;
  localparam int PER   = NDIG * SLOT;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_data;
  logic        lz_en;
  logic [3:0]  dec_val;
  logic [3:0]  digit_en;
  logic        frame_done;

  seg7_scan_ctrl #(.NDIG(NDIG), .DWELL(DWELL), .BLANK(BLANK)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .lz_en      (lz_en),
    .dec_val    (dec_val),
    .digit_en   (digit_en),
    .frame_done (frame_done)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0] dec;
    logic [3:0] en;
    logic       fd;
    logic       rdy;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] m_active = 16'd0;
  logic [15:0] m_pending = 16'd0;
  logic        m_pfull = 1'b0;
  int          m_t = 0;

  // Expected outputs for cycle t of the scan, from plain frame arithmetic.
  function automatic exp_t expect_at(int t, logic [15:0] act, logic pfull, logic lz);
    exp_t        e;
    int          pos;
    int          d;
    int          ph;
    logic [15:0] sh;
    pos   = t % PER;
    d     = pos / SLOT;
    ph    = pos % SLOT;
    sh    = act >> (4 * d);
    e.dec = sh[3:0];
    e.en  = 4'b1111;
    if ((ph >= BLANK) && !(lz && (d >= 1) && (sh == 16'd0))) e.en[d] = 1'b0;
    e.fd  = (pos == PER - 1);
    e.rdy = !pfull;
    return e;
  endfunction

  task automatic check(string name, int got, int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s t=%0d: got %0h expected %0h", name, m_t, got, want);
    end
  endtask

  // Reference model: advances one cycle per rising edge and queues the
  // expected outputs for the cycle that follows.
  initial begin
    logic old_pf;
    forever begin
      @(posedge clock);
      if (!reset_n) begin
        m_active  = 16'd0;
        m_pending = 16'd0;
        m_pfull   = 1'b0;
        m_t       = 0;
        exp_q.push_back(expect_at(0, 16'd0, 1'b0, 1'b0));
      end else begin
        old_pf = m_pfull;
        if (((m_t % PER) == PER - 1) && old_pf) begin
          m_active = m_pending;
          m_pfull  = 1'b0;
        end
        if (wr_valid && !old_pf) begin
          m_pending = wr_data;
          m_pfull   = 1'b1;
        end
        m_t++;
        exp_q.push_back(expect_at(m_t, m_active, m_pfull, lz_en));
      end
    end
  end

  // Monitor: compares DUT outputs against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("dec_val",    int'(dec_val),    int'(e.dec));
        check("digit_en",   int'(digit_en),   int'(e.en));
        check("frame_done", int'(frame_done), int'(e.fd));
        check("wr_ready",   int'(wr_ready),   int'(e.rdy));
      end
    end
  end

  task automatic cycles(int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic write1(logic [15:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    @(negedge clock);
    wr_valid = 1'b0;
  endtask

  // Wait (bounded) until the current cycle is at frame position p.
  task automatic wait_pos(int p);
    int k;
    k = 0;
    while (((m_t % PER) != p) && (k < 200)) begin
      @(negedge clock);
      k++;
    end
    if (k >= 200) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_pos: position %0d not reached, got %0d expected %0d", p, m_t % PER, p);
    end
  endtask

  initial begin
    logic [31:0] r;
    reset_n  = 1'b0;
    wr_valid = 1'b0;
    wr_data  = 16'd0;
    lz_en    = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    cycles(30);

    // Mid-frame write, shown from the next frame.
    cycles(5);
    write1(16'h1234);
    cycles(60);

    // Back-to-back writes: the second waits for the buffer to drain.
    wr_valid = 1'b1;
    wr_data  = 16'hAAAA;
    @(negedge clock);
    wr_data = 16'h5555;
    cycles(70);
    wr_valid = 1'b0;
    cycles(50);

    // Leading-zero suppression.
    lz_en = 1'b1;
    write1(16'h0070);
    cycles(60);
    write1(16'h0000);
    cycles(60);
    lz_en = 1'b0;
    cycles(30);

    // Write landing exactly on the frame_done cycle.
    wait_pos(PER - 1);
    write1(16'h9876);
    cycles(60);

    // Asynchronous reset in the middle of digit 2's lit window.
    wait_pos(2 * SLOT + BLANK + 1);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("rst_dec_val",    int'(dec_val),    0);
    check("rst_digit_en",   int'(digit_en),   15);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_wr_ready",   int'(wr_ready),   1);
    exp_q.delete();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    cycles(30);

    // Randomized traffic with suppression toggling.
    repeat (600) begin
      @(negedge clock);
      r        = $urandom;
      wr_valid = ($urandom_range(0, 5) == 0);
      wr_data  = r[15:0] >> (4 * $urandom_range(0, 4));
      if ($urandom_range(0, 15) == 0) lz_en = ~lz_en;
    end
    wr_valid = 1'b0;
    cycles(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
